// File: rtl/led_matrix_scanner.sv
// led_matrix_scanner
//   Scans a ROWS x COLS LED matrix from a synchronous framebuffer. Each row
//   is fetched, shifted out MSB-first on the column shift register, latched
//   together with one step of the row shift register, and then shown for
//   2^SCREENTIMERWIDTH cycles with PWM brightness on OEB.
//
// Ports
//   clk32mhz    sole clock, rising edge
//   reset       synchronous, active-high
//   enable      scan request, sampled in IDLE and at row boundaries
//   brightness  on-time fraction, latched on DISPLAY entry
//   fb_row      framebuffer row address (current row)
//   fb_data     framebuffer row contents, valid one cycle after fb_row moves
//   CSDI/CCLK   column shift data / clock
//   LE          column latch enable
//   RSDI/RCLK   row shift data / clock
//   OEB         driver output enable, active low
//   frame_done  one-cycle pulse in the cycle the row wraps to 0
//   busy        high whenever not IDLE
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | outputs quiet, row held at 0, waiting for enable
// S_FETCH  | 2 cycles: address RAM, capture row data on the second
// S_SHIFT  | 2*COLS cycles: one CSDI bit per CCLK pulse, MSB first
// S_LATCH  | 4 cycles: RCLK/LE pulse, RSDI marks row 0
// S_DISPLAY| 2^SCREENTIMERWIDTH cycles: PWM on OEB, then advance row

module led_matrix_scanner #(
    parameter int COLS             = 16,
    parameter int ROWS             = 16,
    parameter int SCREENTIMERWIDTH = 10,
    parameter int BRIGHTBITS       = 4,
    parameter int COL_ACTIVE_LOW   = 0,
    localparam int RW              = ($clog2(ROWS) > 1) ? $clog2(ROWS) : 1
) (
    input  logic                  clk32mhz,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [BRIGHTBITS-1:0] brightness,
    output logic [RW-1:0]         fb_row,
    input  logic [COLS-1:0]       fb_data,
    output logic                  CSDI,
    output logic                  CCLK,
    output logic                  LE,
    output logic                  RSDI,
    output logic                  RCLK,
    output logic                  OEB,
    output logic                  frame_done,
    output logic                  busy
);

    // One counter serves every state; it must reach both 2*COLS-1 and the
    // full dwell range.
    localparam int CW = (SCREENTIMERWIDTH > $clog2(2 * COLS)) ? SCREENTIMERWIDTH
                                                             : $clog2(2 * COLS);

    localparam logic [CW-1:0]   FETCH_LAST = CW'(1);
    localparam logic [CW-1:0]   SHIFT_LAST = CW'(2 * COLS - 1);
    localparam logic [CW-1:0]   LATCH_LAST = CW'(3);
    localparam logic [CW-1:0]   LATCH_PULSE = CW'(1);
    localparam logic [CW-1:0]   DISP_LAST  = CW'((1 << SCREENTIMERWIDTH) - 1);
    localparam logic [RW-1:0]   ROW_LAST   = RW'(ROWS - 1);
    localparam logic [COLS-1:0] COL_MASK   = (COL_ACTIVE_LOW != 0) ? {COLS{1'b1}}
                                                                   : {COLS{1'b0}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_SHIFT,
        S_LATCH,
        S_DISPLAY
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [RW-1:0]         row_q, row_d;
    logic [COLS-1:0]       sr_q, sr_d;
    logic [BRIGHTBITS-1:0] bright_q, bright_d;
    logic                  csdi_q, csdi_d;
    logic                  cclk_q, cclk_d;
    logic                  le_q, le_d;
    logic                  rsdi_q, rsdi_d;
    logic                  rclk_q, rclk_d;
    logic                  oeb_q, oeb_d;
    logic                  frame_done_q, frame_done_d;
    logic                  busy_q, busy_d;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + CW'(1);
        row_d        = row_q;
        sr_d         = sr_q;
        bright_d     = bright_q;
        frame_done_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                row_d = '0;
                if (enable) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                // RAM answers one cycle after fb_row moved, so the second
                // FETCH cycle carries valid data.
                if (cnt_q == FETCH_LAST) begin
                    state_d = S_SHIFT;
                    cnt_d   = '0;
                    sr_d    = fb_data ^ COL_MASK;
                end
            end
            S_SHIFT: begin
                // Advance after the CCLK-high half so CSDI is stable across
                // both halves of each bit.
                if (cnt_q[0]) begin
                    sr_d = {sr_q[COLS-2:0], 1'b0};
                end
                if (cnt_q == SHIFT_LAST) begin
                    state_d = S_LATCH;
                    cnt_d   = '0;
                end
            end
            S_LATCH: begin
                if (cnt_q == LATCH_LAST) begin
                    state_d  = S_DISPLAY;
                    cnt_d    = '0;
                    bright_d = brightness;
                end
            end
            S_DISPLAY: begin
                if (cnt_q == DISP_LAST) begin
                    cnt_d = '0;
                    if (row_q == ROW_LAST) begin
                        row_d        = '0;
                        frame_done_d = 1'b1;
                    end else begin
                        row_d = row_q + RW'(1);
                    end
                    if (enable) begin
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_IDLE;
                        row_d   = '0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                row_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next-state values so the registered
    // pins line up with the state they belong to.
    always_comb begin
        busy_d = (state_d != S_IDLE);
        csdi_d = (state_d == S_SHIFT) && sr_d[COLS-1];
        cclk_d = (state_d == S_SHIFT) && cnt_d[0];
        rsdi_d = (state_d == S_LATCH) && (cnt_d != LATCH_LAST) && (row_d == '0);
        rclk_d = (state_d == S_LATCH) && (cnt_d == LATCH_PULSE);
        le_d   = (state_d == S_LATCH) && (cnt_d == LATCH_PULSE);
        oeb_d  = !((state_d == S_DISPLAY) &&
                   (cnt_d[SCREENTIMERWIDTH-1 -: BRIGHTBITS] < bright_d));
    end

    always_ff @(posedge clk32mhz) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            row_q        <= '0;
            sr_q         <= '0;
            bright_q     <= '0;
            csdi_q       <= 1'b0;
            cclk_q       <= 1'b0;
            le_q         <= 1'b0;
            rsdi_q       <= 1'b0;
            rclk_q       <= 1'b0;
            oeb_q        <= 1'b1;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            row_q        <= row_d;
            sr_q         <= sr_d;
            bright_q     <= bright_d;
            csdi_q       <= csdi_d;
            cclk_q       <= cclk_d;
            le_q         <= le_d;
            rsdi_q       <= rsdi_d;
            rclk_q       <= rclk_d;
            oeb_q        <= oeb_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
        end
    end

    assign fb_row     = row_q;
    assign CSDI       = csdi_q;
    assign CCLK       = cclk_q;
    assign LE         = le_q;
    assign RSDI       = rsdi_q;
    assign RCLK       = rclk_q;
    assign OEB        = oeb_q;
    assign frame_done = frame_done_q;
    assign busy       = busy_q;

endmodule
